vga_frame_buffer: RTL and testbench

Parametrised, double-buffered frame store between the pixel-masking datapath (writer) and the VGA controller (reader). The writer fills a back bank in (row, col) order while the controller scans the front bank. Banks swap only at the controller's frame boundary, so no torn frames reach the display. Linear addressing is `row*IMAGE_COL + col`. An optional background clear of the back bank is supported.

---
 rtl/vga_frame_buffer_pkg.sv | 17 +
 rtl/vga_frame_buffer_dpram.sv | 26 ++
 rtl/vga_frame_buffer.sv | 159 +++++++++++++++
 tb/tb_vga_frame_buffer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_frame_buffer_pkg.sv
// Shared constants and write-side FSM encoding for the double-buffered VGA frame store.
package vga_pkg;

   localparam int              IMAGE_ROW = 240;
   localparam int              IMAGE_COL = 320;
   localparam int              PIXEL_W   = 12;
   localparam int              ROW_W     = 8;
   localparam int              COL_W     = 9;
   localparam logic [11:0]     BG_COLOR  = 12'h000;

   typedef enum logic [1:0] {
      FILL      = 2'd0,
      WAIT_SWAP = 2'd1,
      CLEAR     = 2'd2
   } wr_state_e;

endpackage

// File: rtl/vga_frame_buffer_dpram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port (block-RAM style).
module fb_dpram #(
   parameter int ADDR_W = 18,
   parameter int DATA_W = 12
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Separate process so a same-address read sees the pre-write contents.
   always_ff @(posedge clk) begin
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/vga_frame_buffer.sv
// Double-buffered frame store: writer fills the back bank, VGA reader scans the front bank,
// banks swap only on the reader's frame_start.
module vga_frame_buffer #(
   parameter int                    IMAGE_ROW     = vga_pkg::IMAGE_ROW,
   parameter int                    IMAGE_COL     = vga_pkg::IMAGE_COL,
   parameter int                    PIXEL_W       = vga_pkg::PIXEL_W,
   parameter int                    ROW_W         = vga_pkg::ROW_W,
   parameter int                    COL_W         = vga_pkg::COL_W,
   parameter int                    DOUBLE_BUFFER = 1,
   parameter logic [PIXEL_W-1:0]    BG_COLOR      = vga_pkg::BG_COLOR
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_valid,
   input  logic [ROW_W-1:0]   wr_row,
   input  logic [COL_W-1:0]   wr_col,
   input  logic [PIXEL_W-1:0] wr_pixel,
   output logic               wr_ready,
   input  logic               wr_frame_done,
   input  logic               clear_req,
   input  logic               rd_en,
   input  logic [ROW_W-1:0]   rd_row,
   input  logic [COL_W-1:0]   rd_col,
   output logic [PIXEL_W-1:0] rd_pixel,
   output logic               rd_valid,
   input  logic               frame_start,
   output logic               swap_pending,
   output logic               clear_busy,
   output logic               err_oob
);
   import vga_pkg::*;

   localparam int NPIX   = IMAGE_ROW * IMAGE_COL;
   localparam int AW     = $clog2(NPIX);
   localparam int RAM_AW = AW + ((DOUBLE_BUFFER != 0) ? 1 : 0);

   function automatic logic [AW-1:0] lin_addr(input logic [ROW_W-1:0] r,
                                              input logic [COL_W-1:0] c);
      return AW'(r) * AW'(IMAGE_COL) + AW'(c);
   endfunction

   function automatic logic in_range(input logic [ROW_W-1:0] r,
                                     input logic [COL_W-1:0] c);
      return ({1'b0, r} < (ROW_W+1)'(IMAGE_ROW)) && ({1'b0, c} < (COL_W+1)'(IMAGE_COL));
   endfunction

   // Bank bit sits above the linear address; it is dropped entirely in single-bank builds.
   function automatic logic [RAM_AW-1:0] bank_addr(input logic bank, input logic [AW-1:0] lin);
      logic [AW:0] full;
      full = {bank, lin};
      return full[RAM_AW-1:0];
   endfunction

   wr_state_e     state, state_nxt;
   logic          front_bank, front_bank_nxt;
   logic [AW-1:0] clr_cnt;
   logic          clr_last;
   logic          wr_bank, rd_bank;
   logic          wr_fire, wr_inr;

   logic               ram_we;
   logic [RAM_AW-1:0]  ram_waddr, ram_raddr;
   logic [PIXEL_W-1:0] ram_wdata, ram_q;

   logic rd_vld_p1, rd_oob_p1, rd_seen_p1;

   assign wr_bank  = (DOUBLE_BUFFER != 0) ? ~front_bank : 1'b0;
   assign rd_bank  = (DOUBLE_BUFFER != 0) ?  front_bank : 1'b0;
   assign clr_last = (clr_cnt == AW'(NPIX - 1));
   assign wr_inr   = in_range(wr_row, wr_col);
   assign wr_fire  = wr_valid && wr_ready;

   always_comb begin
      state_nxt      = state;
      front_bank_nxt = front_bank;
      wr_ready       = 1'b0;
      swap_pending   = 1'b0;
      clear_busy     = 1'b0;
      case (state)
         FILL: begin
            wr_ready = 1'b1;
            // Frame-done takes priority; a coincident clear request is dropped.
            if (wr_frame_done && (DOUBLE_BUFFER != 0)) state_nxt = WAIT_SWAP;
            else if (clear_req)                        state_nxt = CLEAR;
         end
         WAIT_SWAP: begin
            swap_pending = 1'b1;
            if (frame_start) begin
               front_bank_nxt = ~front_bank;
               state_nxt      = FILL;
            end
         end
         CLEAR: begin
            clear_busy = 1'b1;
            if (clr_last) state_nxt = FILL;
         end
         default: state_nxt = FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= FILL;
         front_bank <= 1'b0;
         clr_cnt    <= '0;
         err_oob    <= 1'b0;
      end else begin
         state      <= state_nxt;
         front_bank <= front_bank_nxt;
         clr_cnt    <= (state == CLEAR && !clr_last) ? clr_cnt + 1'b1 : '0;
         if (wr_fire && !wr_inr) err_oob <= 1'b1;
      end
   end

   always_comb begin
      ram_we    = (wr_fire && wr_inr) || (state == CLEAR);
      ram_waddr = bank_addr(wr_bank, lin_addr(wr_row, wr_col));
      ram_wdata = wr_pixel;
      if (state == CLEAR) begin
         ram_waddr = bank_addr(wr_bank, clr_cnt);
         ram_wdata = BG_COLOR;
      end
   end

   assign ram_raddr = bank_addr(rd_bank, lin_addr(rd_row, rd_col));

   fb_dpram #(
      .ADDR_W (RAM_AW),
      .DATA_W (PIXEL_W)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .re    (rd_en),
      .raddr (ram_raddr),
      .rdata (ram_q)
   );

   // ---- read stage p0 -> p1 ----
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_vld_p1  <= 1'b0;
         rd_seen_p1 <= 1'b0;
      end else begin
         rd_vld_p1 <= rd_en;
         if (rd_en) rd_seen_p1 <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rd_en) rd_oob_p1 <= !in_range(rd_row, rd_col);
   end

   // Output holds the last read; zero until the first read after reset.
   assign rd_pixel = !rd_seen_p1 ? '0 : (rd_oob_p1 ? BG_COLOR : ram_q);
   assign rd_valid = rd_vld_p1;

endmodule

// File: tb/tb_vga_frame_buffer.sv
// Directed self-checking bench for vga_frame_buffer: table-driven pixel writes/reads plus swap, clear and reset sequences.
module tb_vga_frame_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_valid;
   logic [7:0]  wr_row;
   logic [8:0]  wr_col;
   logic [11:0] wr_pixel;
   logic        wr_ready;
   logic        wr_frame_done;
   logic        clear_req;
   logic        rd_en;
   logic [7:0]  rd_row;
   logic [8:0]  rd_col;
   logic [11:0] rd_pixel;
   logic        rd_valid;
   logic        frame_start;
   logic        swap_pending;
   logic        clear_busy;
   logic        err_oob;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      logic [7:0]  row;
      logic [8:0]  col;
      logic [11:0] pix;
   } vec_t;

   vec_t tbl [5];

   always #5 clk = ~clk;

   vga_frame_buffer dut (
      .clk           (clk),
      .rst           (rst),
      .wr_valid      (wr_valid),
      .wr_row        (wr_row),
      .wr_col        (wr_col),
      .wr_pixel      (wr_pixel),
      .wr_ready      (wr_ready),
      .wr_frame_done (wr_frame_done),
      .clear_req     (clear_req),
      .rd_en         (rd_en),
      .rd_row        (rd_row),
      .rd_col        (rd_col),
      .rd_pixel      (rd_pixel),
      .rd_valid      (rd_valid),
      .frame_start   (frame_start),
      .swap_pending  (swap_pending),
      .clear_busy    (clear_busy),
      .err_oob       (err_oob)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] r, input logic [8:0] c, input logic [11:0] p);
      wr_valid = 1'b1; wr_row = r; wr_col = c; wr_pixel = p;
      tick();
      wr_valid = 1'b0;
   endtask

   task automatic rd_check(input string name, input logic [7:0] r, input logic [8:0] c,
                           input logic [11:0] exp);
      rd_en = 1'b1; rd_row = r; rd_col = c;
      tick();
      rd_en = 1'b0;
      check({name, "_vld"}, 32'(rd_valid), 32'd1);
      check(name, 32'(rd_pixel), 32'(exp));
   endtask

   task automatic pulse_done();
      wr_frame_done = 1'b1;
      tick();
      wr_frame_done = 1'b0;
   endtask

   task automatic pulse_fs();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   task automatic swap();
      pulse_done();
      pulse_fs();
   endtask

   initial begin
      int cyc;
      tbl[0] = '{8'd10,  9'd20,  12'hABC};
      tbl[1] = '{8'd0,   9'd200, 12'h123};
      tbl[2] = '{8'd239, 9'd319, 12'hFFF};
      tbl[3] = '{8'd0,   9'd0,   12'h5A5};
      tbl[4] = '{8'd1,   9'd0,   12'h321};

      rst = 1'b1; wr_valid = 1'b0; wr_row = '0; wr_col = '0; wr_pixel = '0;
      wr_frame_done = 1'b0; clear_req = 1'b0; rd_en = 1'b0; rd_row = '0; rd_col = '0;
      frame_start = 1'b0;
      repeat (2) tick();
      rst = 1'b0;

      check("rst_wr_ready", 32'(wr_ready), 32'd1);
      check("rst_rd_valid", 32'(rd_valid), 32'd0);
      check("rst_rd_pixel", 32'(rd_pixel), 32'd0);
      check("rst_err_oob",  32'(err_oob),  32'd0);
      check("rst_swap_pend", 32'(swap_pending), 32'd0);
      check("rst_clear_busy", 32'(clear_busy), 32'd0);

      // Table: fill back bank 1, swap, read back through front bank 1.
      for (int i = 0; i < 5; i++) wr(tbl[i].row, tbl[i].col, tbl[i].pix);
      pulse_done();
      check("done_swap_pend", 32'(swap_pending), 32'd1);
      check("done_wr_ready",  32'(wr_ready),     32'd0);
      pulse_fs();
      check("fs_swap_pend", 32'(swap_pending), 32'd0);
      check("fs_wr_ready",  32'(wr_ready),     32'd1);
      for (int i = 0; i < 5; i++) rd_check($sformatf("tbl_rd%0d", i), tbl[i].row, tbl[i].col, tbl[i].pix);
      tick();
      check("idle_rd_valid", 32'(rd_valid), 32'd0);
      check("idle_rd_hold",  32'(rd_pixel), 32'h321);

      // Swap isolation.
      wr(8'd5, 9'd5, 12'h111);
      swap();
      rd_check("iso_front111", 8'd5, 9'd5, 12'h111);
      wr(8'd5, 9'd5, 12'h222);
      pulse_done();
      check("iso_wait_ready", 32'(wr_ready),     32'd0);
      check("iso_wait_pend",  32'(swap_pending), 32'd1);
      rd_check("iso_wait_rd", 8'd5, 9'd5, 12'h111);
      repeat (3) tick();
      check("iso_still_pend", 32'(swap_pending), 32'd1);
      frame_start = 1'b1;
      rd_check("iso_fs_edge_rd", 8'd5, 9'd5, 12'h111);
      frame_start = 1'b0;
      check("iso_pend_clr", 32'(swap_pending), 32'd0);
      rd_check("iso_after_swap", 8'd5, 9'd5, 12'h222);

      // Out of range: (0,320) would alias (1,0) if not dropped.
      wr(8'd1, 9'd0, 12'h0AA);
      check("oob_before", 32'(err_oob), 32'd0);
      wr(8'd0, 9'd320, 12'hEEE);
      check("oob_col_flag", 32'(err_oob), 32'd1);
      wr(8'd240, 9'd0, 12'hEEE);
      check("oob_row_ready", 32'(wr_ready), 32'd1);
      swap();
      rd_check("oob_no_alias", 8'd1, 9'd0, 12'h0AA);
      rd_check("oob_rd_bg",    8'd0, 9'd320, 12'h000);
      rd_check("oob_rd_row_bg", 8'd240, 9'd0, 12'h000);
      check("oob_sticky", 32'(err_oob), 32'd1);

      // Simultaneous wr_frame_done + frame_start: no swap until the next frame_start.
      wr_frame_done = 1'b1; frame_start = 1'b1;
      tick();
      wr_frame_done = 1'b0; frame_start = 1'b0;
      check("sim_pend", 32'(swap_pending), 32'd1);
      rd_check("sim_no_swap", 8'd1, 9'd0, 12'h0AA);
      pulse_fs();
      rd_check("sim_swapped", 8'd5, 9'd5, 12'h222);

      // clear_req with wr_frame_done: frame_done wins.
      wr_frame_done = 1'b1; clear_req = 1'b1;
      tick();
      wr_frame_done = 1'b0; clear_req = 1'b0;
      check("cd_pend", 32'(swap_pending), 32'd1);
      check("cd_busy", 32'(clear_busy),   32'd0);
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      check("cd_wait_ignores_clear", 32'(clear_busy), 32'd0);
      pulse_fs();
      check("cd_fill_ready", 32'(wr_ready),   32'd1);
      check("cd_fill_busy",  32'(clear_busy), 32'd0);

      // Full clear of back bank 1.
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      check("clr_busy",  32'(clear_busy), 32'd1);
      check("clr_stall", 32'(wr_ready),   32'd0);
      cyc = 0;
      while (clear_busy === 1'b1 && cyc < 80000) begin
         tick();
         cyc++;
      end
      check("clr_len",   32'(cyc),      32'd76800);
      check("clr_ready", 32'(wr_ready), 32'd1);
      swap();
      for (int i = 0; i < 5; i++) rd_check($sformatf("clr_rd%0d", i), tbl[i].row, tbl[i].col, 12'h000);
      rd_check("clr_rd55", 8'd5, 9'd5, 12'h000);

      // Reset mid-clear of back bank 0.
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      repeat (999) tick();
      check("mid_busy", 32'(clear_busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_busy",  32'(clear_busy),   32'd0);
      check("mid_rst_ready", 32'(wr_ready),     32'd1);
      check("mid_rst_pend",  32'(swap_pending), 32'd0);
      check("mid_rst_oob",   32'(err_oob),      32'd0);
      check("mid_rst_vld",   32'(rd_valid),     32'd0);
      check("mid_rst_pix",   32'(rd_pixel),     32'd0);
      rd_check("mid_front0", 8'd5, 9'd5, 12'h111);
      rd_check("mid_partial", 8'd1, 9'd0, 12'h000);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
